// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter: one-entry holding buffer per requester,
// oldest-first grant with round-robin tie-break. Optional bypass ports via RF_WRITE_BYPASS_EN.
module rf_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
`ifdef RF_WRITE_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              byp_hit1,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data1,
  output logic [DATA_W-1:0] byp_data2
`endif
);

  // Handshake: a transfer happens on a rising edge where x_valid & x_ready.
  // x_ready depends only on buffer state and grant, never on x_valid.

  logic              a_full, b_full;
  logic              a_age, b_age;     // set when this entry is strictly older than the other
  logic [ADDR_W-1:0] a_addr_q, b_addr_q;
  logic [DATA_W-1:0] a_data_q, b_data_q;
  logic              ptr_b;            // tie-break pointer: 0 = A, 1 = B

  logic a_grant, b_grant, any_grant, tie;
  logic a_load, b_load, a_keep, b_keep;
  logic a_full_n, b_full_n, a_age_n, b_age_n;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    tie       = a_full & b_full & ~a_age & ~b_age;
    a_grant   = a_full & (~b_full | a_age | (~b_age & ~ptr_b));
    b_grant   = b_full & ~a_grant;
    any_grant = a_grant | b_grant;
    a_ready   = ~a_full | a_grant;
    b_ready   = ~b_full | b_grant;
    a_load    = a_valid & a_ready;
    b_load    = b_valid & b_ready;
    a_keep    = a_full & ~a_grant;
    b_keep    = b_full & ~b_grant;
    a_full_n  = a_load | a_keep;
    b_full_n  = b_load | b_keep;
    sel_addr  = a_grant ? a_addr_q : b_addr_q;
    sel_data  = a_grant ? a_data_q : b_data_q;
    busy      = a_full | b_full | wr_en;
  end

  // An entry that survives an edge while the other side is freshly loaded becomes the older one.
  always_comb begin
    a_age_n = 1'b0;
    b_age_n = 1'b0;
    if (a_full_n && b_full_n) begin
      if (a_keep && b_keep) begin
        a_age_n = a_age;
        b_age_n = b_age;
      end else begin
        a_age_n = a_keep;
        b_age_n = b_keep;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_full   <= 1'b0;
      b_full   <= 1'b0;
      a_age    <= 1'b0;
      b_age    <= 1'b0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      a_data_q <= '0;
      b_data_q <= '0;
      ptr_b    <= 1'b0;
    end else begin
      a_full <= a_full_n;
      b_full <= b_full_n;
      a_age  <= a_age_n;
      b_age  <= b_age_n;
      if (a_load) begin
        a_addr_q <= a_addr;
        a_data_q <= a_data;
      end
      if (b_load) begin
        b_addr_q <= b_addr;
        b_data_q <= b_data;
      end
      if (tie) ptr_b <= a_grant;
    end
  end

  // Register-0 writes still travel the pipeline; only the enable is suppressed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= any_grant & (sel_addr != '0);
      if (any_grant) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  always_comb begin
    byp_hit1  = wr_en & (rd_addr1 == wr_addr) & (rd_addr1 != '0);
    byp_hit2  = wr_en & (rd_addr2 == wr_addr) & (rd_addr2 != '0);
    byp_data1 = byp_hit1 ? wr_data : '0;
    byp_data2 = byp_hit2 ? wr_data : '0;
  end
`endif

endmodule
